atomrvcore_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute-stage ALU. Takes the ALU's registered effective address plus the store data and rd, runs one data-memory transaction over a req/gnt/rvalid bus, and returns sign- or zero-extended load data to writeback. Byte-lane steering is included. Only one access is outstanding at a time; the execute stage is back-pressured through `req_ready_o`.

---
 rtl/atomrvcore_lsu_pkg.sv | 23 ++
 rtl/atomrvcore_lsu_align.sv | 55 +++++
 rtl/atomrvcore_lsu.sv | 136 +++++++++++++
 tb/tb_atomrvcore_lsu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/atomrvcore_lsu_pkg.sv
// Shared types for the atomrvcore load/store unit: access size, decoded op and FSM state.
package atomrvcore_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef struct packed {
        logic      store;
        logic      is_unsigned;
        lsu_size_e size;
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/atomrvcore_lsu_align.sv
// Byte-lane steering: store byte enables and data replication, load shift and extension.
module atomrvcore_lsu_align
    import atomrvcore_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [1:0]  eff_off;
    logic [31:0] shifted;

    // Offset bits below the access size are dropped, so halves only see addr[1] and words see 0.
    always_comb begin
        eff_off    = 2'b00;
        be         = 4'b0000;
        wdata_lane = wdata;
        case (size)
            BYTE: begin
                eff_off    = offset;
                be         = 4'b0001 << eff_off;
                wdata_lane = {4{wdata[7:0]}};
            end
            HALF: begin
                eff_off    = {offset[1], 1'b0};
                be         = 4'b0011 << eff_off;
                wdata_lane = {2{wdata[15:0]}};
            end
            WORD: begin
                eff_off    = 2'b00;
                be         = 4'b1111;
            end
            default: ;
        endcase
    end

    assign shifted = rdata >> {eff_off, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        case (size)
            BYTE:    rdata_ext = is_unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            HALF:    rdata_ext = is_unsigned ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/atomrvcore_lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid data-memory access with writeback.
// Optional ATOMRVCORE_LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses.
module atomrvcore_lsu
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int REGADDR   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           lsu_op_i,
    input  logic [DATAWIDTH-1:0] addr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic [REGADDR-1:0]   rd_i,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [3:0]           dmem_be_o,
    output logic [DATAWIDTH-1:0] dmem_addr_o,
    output logic [DATAWIDTH-1:0] dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [DATAWIDTH-1:0] dmem_rdata_i,
    output logic                 done_o,
    output logic                 wb_we_o,
    output logic [REGADDR-1:0]   wb_rd_o,
    output logic [DATAWIDTH-1:0] wb_data_o,
    output logic                 err_o
);

    lsu_state_e           state_q, state_d;
    lsu_op_t              op_in, op_q;
    logic [DATAWIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic [REGADDR-1:0]   rd_q;
    logic                 err_q;
    logic                 illegal, misalign, fault_in, accept, capture;
    logic [3:0]           lane_be;
    logic [31:0]          lane_wdata, ext_rdata;

    assign op_in   = lsu_op_t'(lsu_op_i);
    assign illegal = !(op_in.size inside {BYTE, HALF, WORD}) || (op_in.store && op_in.is_unsigned);

`ifdef ATOMRVCORE_LSU_MISALIGN_TRAP_EN
    assign misalign = (op_in.size == HALF && addr_i[0]) ||
                      (op_in.size == WORD && addr_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign fault_in = illegal || misalign;
    assign accept   = (state_q == IDLE) && req_valid_i;
    assign capture  = ((state_q == REQ) && dmem_gnt_i && dmem_rvalid_i) ||
                      ((state_q == WAIT) && dmem_rvalid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid_i) state_d = fault_in ? RESP : REQ;
            REQ:  if (dmem_gnt_i)  state_d = dmem_rvalid_i ? RESP : WAIT;
            WAIT: if (dmem_rvalid_i) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= op_in;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                rd_q    <= rd_i;
                err_q   <= fault_in;
            end
            if (capture) rdata_q <= dmem_rdata_i;
        end
    end

    atomrvcore_lsu_align u_align (
        .size        (op_q.size),
        .is_unsigned (op_q.is_unsigned),
        .offset      (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (rdata_q),
        .be          (lane_be),
        .wdata_lane  (lane_wdata),
        .rdata_ext   (ext_rdata)
    );

    // Bus and writeback outputs are decoded from state so they read as zero outside their window.
    always_comb begin
        req_ready_o  = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = '0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        done_o       = 1'b0;
        wb_we_o      = 1'b0;
        wb_rd_o      = '0;
        wb_data_o    = '0;
        err_o        = 1'b0;
        case (state_q)
            IDLE: req_ready_o = 1'b1;
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = op_q.store;
                dmem_be_o    = lane_be;
                dmem_addr_o  = {addr_q[DATAWIDTH-1:2], 2'b00};
                dmem_wdata_o = lane_wdata;
            end
            RESP: begin
                done_o    = 1'b1;
                err_o     = err_q;
                wb_we_o   = !op_q.store && !err_q && (rd_q != '0);
                wb_rd_o   = rd_q;
                wb_data_o = (!op_q.store && !err_q) ? ext_rdata : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_atomrvcore_lsu.sv
// Directed vector bench for atomrvcore_lsu, honouring ATOMRVCORE_LSU_MISALIGN_TRAP_EN.
module tb_atomrvcore_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  lsu_op_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        done_o, wb_we_o, err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    atomrvcore_lsu #(.DATAWIDTH(32), .REGADDR(5)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .lsu_op_i      (lsu_op_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rd_i          (rd_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .done_o        (done_o),
        .wb_we_o       (wb_we_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .err_o         (err_o)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int unsigned gdly;   // cycles of REQ before gnt
        int unsigned rdly;   // cycles from gnt to rvalid (0 = same cycle)
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        wbwe;
        logic [31:0] wbdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge of the idle cycle after RESP.
    task automatic apply(input vec_t v);
        chk({v.name, " ready"}, req_ready_o, 1);
        req_valid_i = 1'b1;
        lsu_op_i    = v.op;
        addr_i      = v.addr;
        wdata_i     = v.wdata;
        rd_i        = v.rd;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lsu_op_i    = '0;
        addr_i      = '0;
        wdata_i     = '0;
        rd_i        = '0;
        if (v.fault) begin
            chk({v.name, " done"}, done_o, 1);
            chk({v.name, " err"}, err_o, 1);
            chk({v.name, " wb_we"}, wb_we_o, 0);
            chk({v.name, " no req"}, dmem_req_o, 0);
        end else begin
            for (int unsigned i = 0; i <= v.gdly; i++) begin
                chk({v.name, " req"}, dmem_req_o, 1);
                chk({v.name, " we"}, dmem_we_o, v.op[3]);
                chk({v.name, " be"}, dmem_be_o, v.be);
                chk({v.name, " addr"}, dmem_addr_o, v.baddr);
                if (v.op[3]) chk({v.name, " wdata"}, dmem_wdata_o, v.bwdata);
                chk({v.name, " early done"}, done_o, 0);
                if (i == v.gdly) begin
                    dmem_gnt_i = 1'b1;
                    if (v.rdly == 0) begin
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i  = v.rdata;
                    end
                end
                @(negedge clk_i);
                dmem_gnt_i    = 1'b0;
                dmem_rvalid_i = 1'b0;
            end
            for (int unsigned j = 1; j <= v.rdly; j++) begin
                chk({v.name, " wait req"}, dmem_req_o, 0);
                chk({v.name, " wait done"}, done_o, 0);
                if (j == v.rdly) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = v.rdata;
                end
                @(negedge clk_i);
                dmem_rvalid_i = 1'b0;
            end
            chk({v.name, " done"}, done_o, 1);
            chk({v.name, " err"}, err_o, 0);
            chk({v.name, " wb_we"}, wb_we_o, v.wbwe);
            if (v.wbwe) begin
                chk({v.name, " wb_rd"}, wb_rd_o, v.rd);
                chk({v.name, " wb_data"}, wb_data_o, v.wbdata);
            end
        end
        dmem_rdata_i = '0;
        @(negedge clk_i);
        chk({v.name, " done pulse"}, done_o, 0);
        chk({v.name, " idle err"}, err_o, 0);
        chk({v.name, " idle wb_we"}, wb_we_o, 0);
        chk({v.name, " ready after"}, req_ready_o, 1);
    endtask

    initial begin
        //          name         op       addr          wdata         rd  gd rd rdata         flt be       baddr         bwdata        wbwe wbdata
        vecs[0]  = '{"lw",      4'b0010, 32'h100,      32'h0,        5,  0, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h100,      32'h0,        1, 32'hDEADBEEF};
        vecs[1]  = '{"lb",      4'b0000, 32'h103,      32'h0,        6,  0, 0, 32'h80FFFFFF, 0, 4'b1000, 32'h100,      32'h0,        1, 32'hFFFFFF80};
        vecs[2]  = '{"lbu",     4'b0100, 32'h103,      32'h0,        6,  0, 0, 32'h80FFFFFF, 0, 4'b1000, 32'h100,      32'h0,        1, 32'h00000080};
        vecs[3]  = '{"sh",      4'b1001, 32'h102,      32'h1234ABCD, 0,  3, 1, 32'h0,        0, 4'b1100, 32'h100,      32'hABCDABCD, 0, 32'h0};
`ifdef ATOMRVCORE_LSU_MISALIGN_TRAP_EN
        vecs[4]  = '{"lw_mis",  4'b0010, 32'h101,      32'h0,        7,  0, 0, 32'h11223344, 1, 4'b0000, 32'h0,        32'h0,        0, 32'h0};
        vecs[11] = '{"lh_mis",  4'b0001, 32'h103,      32'h0,        8,  0, 0, 32'h87654321, 1, 4'b0000, 32'h0,        32'h0,        0, 32'h0};
`else
        vecs[4]  = '{"lw_mis",  4'b0010, 32'h101,      32'h0,        7,  0, 0, 32'h11223344, 0, 4'b1111, 32'h100,      32'h0,        1, 32'h11223344};
        vecs[11] = '{"lh_mis",  4'b0001, 32'h103,      32'h0,        8,  1, 0, 32'h87654321, 0, 4'b1100, 32'h100,      32'h0,        1, 32'hFFFF8765};
`endif
        vecs[5]  = '{"illegal", 4'b0011, 32'h100,      32'h0,        3,  0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        0, 32'h0};
        vecs[6]  = '{"lw_rd0",  4'b0010, 32'h200,      32'h0,        0,  0, 0, 32'h00000055, 0, 4'b1111, 32'h200,      32'h0,        0, 32'h0};
        vecs[7]  = '{"lh",      4'b0001, 32'h102,      32'h0,        9,  0, 2, 32'h87654321, 0, 4'b1100, 32'h100,      32'h0,        1, 32'hFFFF8765};
        vecs[8]  = '{"lhu",     4'b0101, 32'h102,      32'h0,        9,  2, 0, 32'h87654321, 0, 4'b1100, 32'h100,      32'h0,        1, 32'h00008765};
        vecs[9]  = '{"sb",      4'b1000, 32'h101,      32'h000000A5, 0,  1, 2, 32'h0,        0, 4'b0010, 32'h100,      32'hA5A5A5A5, 0, 32'h0};
        vecs[10] = '{"sw",      4'b1010, 32'h10C,      32'hCAFEF00D, 0,  0, 0, 32'h0,        0, 4'b1111, 32'h10C,      32'hCAFEF00D, 0, 32'h0};
        vecs[12] = '{"sbu",     4'b1100, 32'h100,      32'h0,        4,  0, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        0, 32'h0};

        rst_i = 1'b1;
        req_valid_i = 1'b0;
        lsu_op_i = '0;
        addr_i = '0;
        wdata_i = '0;
        rd_i = '0;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst ready", req_ready_o, 1);
        chk("rst req", dmem_req_o, 0);
        chk("rst we", dmem_we_o, 0);
        chk("rst be", dmem_be_o, 0);
        chk("rst addr", dmem_addr_o, 0);
        chk("rst wdata", dmem_wdata_o, 0);
        chk("rst done", done_o, 0);
        chk("rst wb_we", wb_we_o, 0);
        chk("rst wb_rd", wb_rd_o, 0);
        chk("rst wb_data", wb_data_o, 0);
        chk("rst err", err_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int k = 0; k < 13; k++) apply(vecs[k]);

        // Reset while REQ is held: the request must drop without waiting for a clock edge.
        req_valid_i = 1'b1; lsu_op_i = 4'b0010; addr_i = 32'h300; rd_i = 5'd9;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rstreq req", dmem_req_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rstreq drop", dmem_req_o, 0);
        chk("rstreq ready", req_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset in WAIT followed by a stale rvalid.
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        chk("rstwait in wait", dmem_req_o, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h12345678;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        chk("late rvalid done", done_o, 0);
        chk("late rvalid req", dmem_req_o, 0);
        chk("late rvalid ready", req_ready_o, 1);
        @(negedge clk_i);
        chk("late rvalid done2", done_o, 0);
        apply(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
